dmem_responder: RTL

Memory-side responder for the 16-bit CPU's load/store port. It accepts one load or store per request on a req/ack handshake and inserts a programmable number of wait states. It owns the word storage, and flags misaligned or out-of-range accesses. It sits between the CPU's data-access initiator and backing storage, and allows the core to be run against a slow memory.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Load/store bus between the CPU data-access initiator and dmem_responder.
// Request side is driven by the master; completion side by the slave.
interface dmem_if #(
   parameter int ADDR_WIDTH = 16
) ();
   logic                  req;
   logic                  we;
   logic [ADDR_WIDTH-1:0] addr;
   logic [15:0]           wdata;
   logic                  ack;
   logic [15:0]           rdata;
   logic                  err;
   logic                  busy;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata, err, busy
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata, err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-storage responder for the 16-bit CPU data port with
// programmable wait states and misaligned/out-of-range error flagging.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 16,
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input logic    clk,
   input logic    reset,
   dmem_if.slave  bus
);
   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           wdata_q, wdata_d;
   logic                  ack_q, ack_d;
   logic                  err_q, err_d;
   logic [15:0]           rdata_q, rdata_d;
   logic [15:0]           mem_q [DEPTH_WORDS];

   logic                  complete;
   logic                  c_we;
   logic [ADDR_WIDTH-1:0] c_addr;
   logic [15:0]           c_wdata;
   logic [ADDR_WIDTH-2:0] c_idx;
   logic                  c_err;
   logic                  wr_en;
   logic [IW-1:0]         wr_idx;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      rdata_d  = rdata_q;
      complete = 1'b0;
      c_we     = we_q;
      c_addr   = addr_q;
      c_wdata  = wdata_q;
      wr_en    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               if (WAIT_CYCLES == 0) begin
                  // zero wait states: complete on the accept edge itself
                  complete = 1'b1;
                  c_we     = bus.we;
                  c_addr   = bus.addr;
                  c_wdata  = bus.wdata;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CW'(WAIT_CYCLES);
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) complete = 1'b1;
         end
         RESP: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      c_idx  = c_addr[ADDR_WIDTH-1:1];
      c_err  = c_addr[0] | (32'(c_idx) >= DEPTH_WORDS);
      wr_idx = c_idx[IW-1:0];

      if (complete) begin
         state_d = RESP;
         ack_d   = 1'b1;
         if (c_err) begin
            err_d   = 1'b1;
            rdata_d = 16'h0000;
         end else if (c_we) begin
            wr_en = 1'b1;
         end else begin
            rdata_d = mem_q[wr_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // reset wins over a write landing on the same edge
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[wr_idx] <= c_wdata;
      end
   end

   assign bus.ack   = ack_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign bus.busy  = (state_q != IDLE);
endmodule
